// File: rtl/riscv_pkg.sv
// Types and constants shared between the fetch front end and the control decoder.
package riscv_pkg;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch bus: instruction-memory request/response, redirect input and decode output slot.
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_opcode,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC register, single-outstanding imem request FSM
// and a valid/ready output slot feeding the control decoder.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;

  logic slot_free;
  logic req_valid;
  logic req_fire;

  // A request is only issued when its response is guaranteed an empty slot.
  assign slot_free = !id_valid_q || bus.id_ready;
  assign req_valid = rst_n && (state_q == S_REQ) && slot_free;
  assign req_fire  = req_valid && bus.imem_req_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    if (id_valid_q && bus.id_ready) begin
      id_valid_d = 1'b0;
    end

    if (bus.redirect_valid) begin
      // Anything already requested belongs to the old path and must be discarded.
      pc_d       = bus.redirect_pc & ALIGN_MASK;
      id_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
            if (!drop_q) begin
              id_instr_d = bus.imem_rsp_data;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
              pc_d       = pc_q + PC_STEP;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_opcode      = opcode_of(id_instr_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-side instruction memory, in-order stream
// model of delivered instructions, and literal checks around reset/redirect/stall.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tbl [8];
  logic [31:0] exp_pc;
  logic [31:0] last_id_pc;
  int          cyc_n = 0;
  int          last_cons_cyc;
  bit          chk_gap = 1'b0;
  int          n_cons = 0;
  bit          last_hs;
  int          lat = 1;
  bit          pend = 1'b0;
  int          pcnt;
  logic [31:0] paddr;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a < 32'd20) return tbl[a[4:2]];
    return {a[26:2], OP_I};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // One clock cycle: sample just after the inputs settle, update the model at
  // the edge, then play instruction memory at the following falling edge.
  task automatic cyc();
    bit          hs, cons;
    logic [31:0] w;
    #1;
    hs   = bus.imem_req_valid && bus.imem_req_ready;
    cons = bus.id_valid && bus.id_ready && !bus.redirect_valid;
    if (bus.id_valid && !bus.id_ready) chk("req_gated_slot_full", bus.imem_req_valid, 0);
    if (cons) begin
      w = memw(exp_pc);
      chk("stream_id_pc", bus.id_pc, exp_pc);
      chk("stream_id_instr", bus.id_instr, w);
      chk("stream_id_opcode", {25'd0, bus.id_opcode}, {25'd0, w[6:0]});
      if (chk_gap && last_cons_cyc >= 0) chk("issue_gap", cyc_n - last_cons_cyc, 2);
      last_cons_cyc = cyc_n;
      last_id_pc    = bus.id_pc;
      n_cons++;
      exp_pc = exp_pc + 32'd4;
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
    if (hs) begin
      pend  = 1'b1;
      pcnt  = lat;
      paddr = bus.imem_addr;
    end
    last_hs = hs;
    @(negedge clk);
    cyc_n++;
    bus.imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = memw(paddr);
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
  endtask

  task automatic run_until_hs(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (last_hs) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(nm, 0, 1);
  endtask

  task automatic run_until_req(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.imem_req_valid) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    if (!got) chk(nm, 0, 1);
  endtask

  task automatic run_cons(input int k, input string nm);
    int start = n_cons;
    for (int i = 0; i < 100; i++) begin
      if (n_cons >= start + k) break;
      cyc();
    end
    if (n_cons < start + k) chk(nm, n_cons - start, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = 32'h0000_0013;
    tbl[0] = 32'h0050_0093;
    exp_pc = 32'h0;
    last_cons_cyc = -1;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_req_valid", bus.imem_req_valid, 0);

    // Test 1: first fetch after reset release, k=1.
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    #1;
    chk("t1_req_valid", bus.imem_req_valid, 1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    cyc();
    cyc();
    #1;
    chk("t1_id_valid", bus.id_valid, 1);
    chk("t1_id_pc", bus.id_pc, 32'h0);
    chk("t1_opcode", {25'd0, bus.id_opcode}, {25'd0, 7'b0010011});
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    cyc();
    bus.id_ready = 1'b0;
    cyc();
    cyc();

    // Test 2: stream five instruction types from 0x0 at full rate.
    tbl[0] = 32'h0020_81B3;
    tbl[1] = 32'h0050_0093;
    tbl[2] = 32'h0000_A103;
    tbl[3] = 32'h0020_A223;
    tbl[4] = 32'h0020_8463;
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    cyc();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    chk_gap       = 1'b1;
    last_cons_cyc = -1;
    run_cons(5, "t2_stream_timeout");
    chk_gap = 1'b0;
    chk("t2_last_pc", last_id_pc, 32'h10);

    // Test 3: decode stall holds the slot and blocks requests.
    bus.id_ready = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("t3_held_pc", bus.id_pc, 32'h14);
    chk("t3_held_instr", bus.id_instr, 32'h0000_0293);
    bus.id_ready = 1'b1;
    #1;
    chk("t3_req_on_ready", bus.imem_req_valid, 1);
    chk("t3_req_addr", bus.imem_addr, 32'h18);
    cyc();

    // Test 4: redirect while waiting, stale response two cycles later.
    lat = 2;
    run_until_hs("t4_hs_timeout");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", bus.id_valid, 0);
    cyc();
    #1;
    chk("t4_no_stale", bus.id_valid, 0);
    chk("t4_req_valid", bus.imem_req_valid, 1);
    chk("t4_addr", bus.imem_addr, 32'h100);
    run_cons(1, "t4_cons_timeout");
    chk("t4_first_pc", last_id_pc, 32'h100);

    // Test 5a: redirect in the same cycle as the response; misaligned target.
    lat = 1;
    run_until_hs("t5a_hs_timeout");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5a_no_stale", bus.id_valid, 0);
    chk("t5a_req_valid", bus.imem_req_valid, 1);
    chk("t5a_addr", bus.imem_addr, 32'h200);
    run_cons(1, "t5a_cons_timeout");
    chk("t5a_first_pc", last_id_pc, 32'h200);

    // Test 5b: redirect in the same cycle as a request handshake.
    run_until_req("t5b_req_timeout");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5b_flushed", bus.id_valid, 0);
    cyc();
    #1;
    chk("t5b_no_stale", bus.id_valid, 0);
    chk("t5b_addr", bus.imem_addr, 32'h300);
    run_cons(1, "t5b_cons_timeout");
    chk("t5b_first_pc", last_id_pc, 32'h300);

    // Test 6: asynchronous reset while a response is outstanding.
    lat = 3;
    run_until_hs("t6_hs_timeout");
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_id_valid", bus.id_valid, 0);
    chk("t6_rst_id_instr", bus.id_instr, 32'h0000_0013);
    chk("t6_rst_id_pc", bus.id_pc, 32'h0);
    chk("t6_rst_req_valid", bus.imem_req_valid, 0);
    chk("t6_rst_addr", bus.imem_addr, 32'h0);
    pend               = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    exp_pc             = 32'h0;
    lat                = 1;
    bus.imem_req_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    #1;
    chk("t6_late_rsp_ignored", bus.id_valid, 0);
    bus.imem_req_ready = 1'b1;
    #1;
    chk("t6_req_valid", bus.imem_req_valid, 1);
    chk("t6_addr", bus.imem_addr, 32'h0);
    run_cons(1, "t6_cons_timeout");
    chk("t6_first_pc", last_id_pc, 32'h0);

    // PC wrap at the top of the address space.
    run_until_req("wrap_req_timeout");
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    run_cons(1, "wrap_cons_timeout");
    chk("wrap_top_pc", last_id_pc, 32'hFFFF_FFFC);
    run_cons(1, "wrap_cons2_timeout");
    chk("wrap_zero_pc", last_id_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
